// File: rtl/seq_mult_4bit.sv
// Sequential 4x4 unsigned shift-add multiplier that borrows an external
// combinational 4-bit adder; one partial-product iteration per clock.
module seq_mult_4bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_s,
  input  logic       add_cout,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_m,     w_m_nxt;
  logic [3:0]  r_acc,   w_acc_nxt;
  logic [3:0]  r_q,     w_q_nxt;
  logic [1:0]  r_cnt,   w_cnt_nxt;
  logic [7:0]  r_product, w_product_nxt;
  logic        r_done,  w_done_nxt;
  logic [3:0]  w_add_a, w_add_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_m       <= 4'd0;
      r_acc     <= 4'd0;
      r_q       <= 4'd0;
      r_cnt     <= 2'd0;
      r_product <= 8'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_m       <= w_m_nxt;
      r_acc     <= w_acc_nxt;
      r_q       <= w_q_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_m_nxt       = r_m;
    w_acc_nxt     = r_acc;
    w_q_nxt       = r_q;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    w_done_nxt    = 1'b0;
    w_add_a       = 4'd0;
    w_add_b       = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_m_nxt     = a_in;
          w_q_nxt     = b_in;
          w_acc_nxt   = 4'd0;
          w_cnt_nxt   = 2'd0;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_add_a   = r_acc;
        w_add_b   = r_q[0] ? r_m : 4'd0;
        // Shift the 5-bit sum right into {Acc,Q}; the dropped LSB lands in Q.
        w_acc_nxt = {add_cout, add_s[3:1]};
        w_q_nxt   = {add_s[0], r_q[3:1]};
        w_cnt_nxt = r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          w_product_nxt = {add_cout, add_s, r_q[3:1]};
          w_done_nxt    = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign add_a   = w_add_a;
  assign add_b   = w_add_b;
  assign product = r_product;
  assign busy    = (r_state == S_CALC);
  assign done    = r_done;

endmodule

// File: tb/tb_seq_mult_4bit.sv
// Randomized and directed checks of seq_mult_4bit against an arithmetic model;
// the bench supplies the combinational adder the block expects downstream.
module tb_seq_mult_4bit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a_in = 4'd0, b_in = 4'd0;
  logic [3:0] add_a, add_b, add_s;
  logic       add_cout;
  logic [7:0] product;
  logic       busy, done;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  seq_mult_4bit dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
    .product(product), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_start(input int a, input int b);
    a_in  = 4'(a);
    b_in  = 4'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full operation with per-iteration checks of the adder operands derived
  // from the partial product a*(b mod 2^i) >> i.
  task automatic run_checked(input int a, input int b);
    int exp_acc;
    apply_start(a, b);
    for (int i = 0; i < 4; i++) begin
      exp_acc = ((a * (b % (1 << i))) >> i) & 15;
      chk("busy_iter", int'(busy), 1);
      chk("done_iter", int'(done), 0);
      chk("add_a", int'(add_a), exp_acc);
      chk("add_b", int'(add_b), ((b >> i) & 1) ? a : 0);
      tick();
    end
    chk("done_pulse", int'(done), 1);
    chk("busy_at_done", int'(busy), 0);
    chk("product", int'(product), a * b);
    chk("add_b_idle", int'(add_b), 0);
  endtask

  // Returns the number of edges until done is seen, or -1 past the budget.
  task automatic wait_done(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int a, b, edges, seen;

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_add_a", int'(add_a), 0);
    chk("rst_add_b", int'(add_b), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    run_checked(3, 5);
    tick();
    chk("done_once", int'(done), 0);
    chk("product_held", int'(product), 15);

    run_checked(15, 15);
    run_checked(0, 9);
    run_checked(9, 0);
    tick();

    // start held across the whole operation; restart on the done cycle
    a_in = 4'd6; b_in = 4'd7; start = 1'b1;
    tick();
    wait_done(8, edges);
    chk("hold_latency", edges, 4);
    chk("hold_product", int'(product), 42);
    a_in = 4'd2; b_in = 4'd3;
    tick();
    start = 1'b0;
    wait_done(8, edges);
    chk("b2b_latency", edges + 1, 5);
    chk("b2b_product", int'(product), 6);
    tick();

    // start while busy is ignored
    apply_start(13, 11);
    tick();
    a_in = 4'd1; b_in = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(8, edges);
    chk("ign_latency", edges + 2, 4);
    chk("ign_product", int'(product), 143);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen += int'(done) + int'(busy);
    end
    chk("ign_no_second", seen, 0);

    // reset mid-operation aborts
    apply_start(10, 10);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_product", int'(product), 0);
    chk("abort_add_a", int'(add_a), 0);
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen += int'(done);
    end
    chk("abort_no_done", seen, 0);
    chk("abort_product_after", int'(product), 0);
    run_checked(4, 4);

    // randomized back-to-back operations
    for (int n = 0; n < 25; n++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      run_checked(a, b);
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
